// File: rtl/adder8_arbiter.sv
// adder8_arbiter: shares one WIDTH-bit adder between two requesters.
// Each requester holds req plus an operand pair until it sees its ack.
// The granted pair is captured, added in EXEC, and the result is presented
// in RESP together with the id of the requester that owns it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; the only state in which an ack can issue
// EXEC  | captured operands are added; result registers load on exit
// RESP  | res_valid strobes for one cycle, then back to IDLE
//
// Ack is combinational from req/ena so the requester learns of the grant
// in the same cycle it is taken. All res_* outputs come from flops only.
module adder8_arbiter #(
  parameter int WIDTH      = 8,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_id_q, op_id_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             res_id_q, res_id_d;

  logic             sel0, sel1;
  logic [WIDTH:0]   sum_full;

  // Arbiter: a lone request wins; on a tie the requester that did not win
  // last time goes next, unless fixed priority hands it to requester 0.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (req0 && req1) begin
      if (PRIO_FIXED || last_grant_q) begin
        sel0 = 1'b1;
      end else begin
        sel1 = 1'b1;
      end
    end else begin
      sel0 = req0;
      sel1 = req1;
    end
  end

  assign ack0 = (state_q == IDLE) && ena && sel0;
  assign ack1 = (state_q == IDLE) && ena && sel1;

  assign sum_full = {1'b0, op_a_q} + {1'b0, op_b_q};

  // Next-state logic: capture on ack, load the result on leaving EXEC.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    last_grant_d = last_grant_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_id_d     = res_id_q;
    case (state_q)
      IDLE: begin
        if (ack0) begin
          op_a_d       = a0;
          op_b_d       = b0;
          op_id_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (ack1) begin
          op_a_d       = a1;
          op_b_d       = b1;
          op_id_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_sum_d  = sum_full[WIDTH-1:0];
        res_cout_d = sum_full[WIDTH];
        res_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0
  // wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      last_grant_q <= last_grant_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_id_q     <= res_id_d;
    end
  end

  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder8_arbiter.sv
// Bench for adder8_arbiter: round-robin instance checked by a scoreboard
// fed from a cycle-level reference model, plus a fixed-priority instance
// exercised with directed contention.
module tb_adder8_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, res_valid, res_id, res_cout, busy;
  logic [W-1:0] res_sum;

  logic         req0_f = 1'b0, req1_f = 1'b0;
  logic         ack0_f, ack1_f, res_valid_f, res_id_f, res_cout_f, busy_f;
  logic [W-1:0] res_sum_f;

  adder8_arbiter #(.WIDTH(W), .PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .res_cout(res_cout), .busy(busy)
  );

  adder8_arbiter #(.WIDTH(W), .PRIO_FIXED(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0(req0_f), .a0(a0), .b0(b0), .ack0(ack0_f),
    .req1(req1_f), .a1(a1), .b1(b1), .ack1(ack1_f),
    .res_valid(res_valid_f), .res_id(res_id_f), .res_sum(res_sum_f),
    .res_cout(res_cout_f), .busy(busy_f)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [W:0] sum;
    int         due;
  } exp_t;

  exp_t        sb[$];
  int          m_last = 1;
  int          m_next_free = 0;
  logic [W+1:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted op occupies the adder for three cycles;
  // ties go to whichever requester did not win last time.
  task automatic tick(output int g);
    int   want;
    exp_t e;
    @(negedge clk);
    want = -1;
    chk("busy", 32'(busy), 32'(cyc < m_next_free));
    if (ena && cyc >= m_next_free) begin
      if (req0 && req1) want = (m_last == 0) ? 1 : 0;
      else if (req0)    want = 0;
      else if (req1)    want = 1;
    end
    chk("ack0", 32'(ack0), 32'(want == 0));
    chk("ack1", 32'(ack1), 32'(want == 1));
    if (want >= 0) begin
      e.id  = want;
      e.sum = (want == 0) ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a1} + {1'b0, b1});
      e.due = cyc + 2;
      sb.push_back(e);
      m_last      = want;
      m_next_free = cyc + 3;
    end
    g = want;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle either the head result is due and must appear,
  // or res_valid stays low and the previous result is held.
  logic mon_due;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_due = (sb.size() > 0) && (sb[0].due == cyc);
      chk("res_valid", 32'(res_valid), 32'(mon_due));
      if (mon_due) begin
        mon_e = sb.pop_front();
        chk("res_sum", 32'(res_sum), 32'(mon_e.sum[W-1:0]));
        chk("res_cout", 32'(res_cout), 32'(mon_e.sum[W]));
        chk("res_id", 32'(res_id), 32'(mon_e.id));
        held = {mon_e.id[0], mon_e.sum};
      end else begin
        chk("res_hold", 32'({res_id, res_cout, res_sum}), 32'(held));
      end
    end
  end

  task automatic op1(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    int g;
    if (r == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; a1 = a; b1 = b; end
    g = -1;
    for (int i = 0; i < 10 && g != r; i++) tick(g);
    chk("grant_wait", 32'(g), 32'(r));
    req0 = 1'b0;
    req1 = 1'b0;
    tick(g);
    tick(g);
  endtask

  logic [W:0] fp_exp;

  initial begin
    int g;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    fp_exp = '0;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({res_valid, res_id, res_cout, res_sum, busy}), 32'(0));
    chk("rst_outputs_fp", 32'({res_valid_f, res_id_f, res_cout_f, res_sum_f, busy_f}), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ena   = 1'b1;
    tick(g);

    // Single op and carry/wrap cases
    op1(0, 8'h12, 8'h34);
    op1(1, 8'hFF, 8'h01);
    op1(1, 8'h80, 8'h80);
    op1(1, 8'h7F, 8'h01);

    // Round-robin under continuous contention
    req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
    req1 = 1'b1; a1 = 8'hA0; b1 = 8'h70;
    for (int k = 0; k < 12; k++) begin
      tick(g);
      if (g == 0) begin a0 = W'($urandom); b0 = W'($urandom); end
      if (g == 1) begin a1 = W'($urandom); b1 = W'($urandom); end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick(g);

    // Fixed priority: requester 0 takes every slot while it asks
    req0_f = 1'b1; req1_f = 1'b1;
    a0 = 8'h3C; b0 = 8'h4D; a1 = 8'h55; b1 = 8'hAA;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("fp_ack0", 32'(ack0_f), 32'(k % 3 == 0));
      chk("fp_ack1", 32'(ack1_f), 32'(0));
      if (k % 3 == 2) begin
        chk("fp_valid", 32'(res_valid_f), 32'(1));
        chk("fp_id", 32'(res_id_f), 32'(0));
        chk("fp_sum", 32'({res_cout_f, res_sum_f}), 32'(fp_exp));
      end
      if (k % 3 == 0) fp_exp = {1'b0, a0} + {1'b0, b0};
      @(posedge clk);
      #1;
      if (k % 3 == 0) begin a0 = W'($urandom); b0 = W'($urandom); end
    end
    req0_f = 1'b0;
    @(negedge clk);
    chk("fp_ack1_after_drop", 32'(ack1_f), 32'(1));
    chk("fp_ack0_after_drop", 32'(ack0_f), 32'(0));
    fp_exp = {1'b0, a1} + {1'b0, b1};
    @(posedge clk);
    #1;
    req1_f = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fp_valid1", 32'(res_valid_f), 32'(1));
    chk("fp_id1", 32'(res_id_f), 32'(1));
    chk("fp_sum1", 32'({res_cout_f, res_sum_f}), 32'(fp_exp));
    @(posedge clk);
    #1;
    repeat (2) tick(g);

    // ena gating: no ack while low, ack as soon as it rises, op completes
    // even if ena drops during EXEC
    ena = 1'b0;
    req0 = 1'b1; a0 = 8'h5A; b0 = 8'h33;
    repeat (5) tick(g);
    ena = 1'b1;
    tick(g);
    chk("ena_grant", 32'(g), 32'(0));
    ena  = 1'b0;
    req0 = 1'b0;
    tick(g);
    tick(g);
    ena = 1'b1;
    tick(g);

    // Randomized traffic with withdrawals and ena toggling
    for (int k = 0; k < 400; k++) begin
      ena = ($urandom_range(7) != 0);
      if (!req0) begin
        if ($urandom_range(2) == 0) begin req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom); end
      end else if ($urandom_range(19) == 0) req0 = 1'b0;
      if (!req1) begin
        if ($urandom_range(2) == 0) begin req1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom); end
      end else if ($urandom_range(19) == 0) req1 = 1'b0;
      tick(g);
      if (g == 0) begin
        if ($urandom_range(1) == 1) begin a0 = W'($urandom); b0 = W'($urandom); end
        else req0 = 1'b0;
      end
      if (g == 1) begin
        if ($urandom_range(1) == 1) begin a1 = W'($urandom); b1 = W'($urandom); end
        else req1 = 1'b0;
      end
    end
    ena = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick(g);

    // Reset in the EXEC cycle discards the op
    op1(1, 8'hC3, 8'h5E);
    req0 = 1'b1; a0 = 8'h21; b0 = 8'h43;
    g = -1;
    for (int i = 0; i < 10 && g != 0; i++) tick(g);
    chk("mid_grant", 32'(g), 32'(0));
    req0 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({res_valid, res_id, res_cout, res_sum, busy, ack0, ack1}), 32'(0));
    sb.delete();
    held        = '0;
    m_last      = 1;
    m_next_free = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick(g);
    req0 = 1'b1; a0 = 8'h0F; b0 = 8'hF1;
    req1 = 1'b1; a1 = 8'h44; b1 = 8'h09;
    tick(g);
    chk("post_rst_ack0", 32'(g), 32'(0));
    req0 = 1'b0;
    repeat (3) tick(g);
    req1 = 1'b0;
    repeat (4) tick(g);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
